// File: rtl/resampler_frame_sched.sv
// Purpose : per-frame scheduler that pops every enabled resampler channel once, gathers the
//           per-channel results and commits them as one wide frame word.
// Latency : frame_i at t -> core_pop_o at t+1; last accepted ack at u -> frame_valid_o at u+1.
// Backpressure: none; a frame_i that arrives while a frame is in flight is dropped and flagged
//           on overrun_o. One ack per cycle is taken (lowest pending index); others stay pending.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   frame_i, ch_en_i         frame strobe and the per-channel enable sampled with it
//   core_pop_o               one-cycle pop to the resampler core (the pending mask, in ISSUE only)
//   core_data_i, core_ack_i  resampler core result and per-channel completion
//   frame_data_o             committed frame, channel n in bits [24n+23:24n]
//   frame_valid_o            one-cycle pulse in the cycle frame_data_o has just been updated
//   busy_o                   high whenever a frame is in flight (state is not IDLE)
//   overrun_o                one-cycle pulse the cycle after a dropped frame_i
//   timeout_o                one-cycle pulse, coincident with frame_valid_o, for an incomplete frame

module resampler_frame_sched #(
    parameter int NUM_CH       = 8,
    parameter int NUM_CH_LOG2  = 3,
    parameter int TIMEOUT      = 1024,
    parameter int TIMEOUT_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_i,
    input  logic [NUM_CH-1:0]      ch_en_i,
    output logic [NUM_CH-1:0]      core_pop_o,
    input  logic [23:0]            core_data_i,
    input  logic [NUM_CH-1:0]      core_ack_i,
    output logic [24*NUM_CH-1:0]   frame_data_o,
    output logic                   frame_valid_o,
    output logic                   busy_o,
    output logic                   overrun_o,
    output logic                   timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam logic [TIMEOUT_LOG2-1:0] TO_LAST = TIMEOUT_LOG2'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [NUM_CH-1:0]       r_pending;
    logic [TIMEOUT_LOG2-1:0] r_to_cnt;
    logic [23:0]             r_stage [NUM_CH];
    logic [24*NUM_CH-1:0]    r_frame;
    logic                    r_overrun;
    logic                    r_timeout;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    state_t                  w_state_nxt;
    logic [NUM_CH-1:0]       w_acc_vec;
    logic                    w_acc_any;
    logic [NUM_CH_LOG2-1:0]  w_acc_idx;
    logic [NUM_CH-1:0]       w_acc_onehot;
    logic [NUM_CH-1:0]       w_pending_nxt;
    logic                    w_timeout_hit;
    logic                    w_enter_commit;

    // Acks are only meaningful while the frame is collecting, and only for
    // channels still outstanding.
    assign w_acc_vec = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) ?
                       (core_ack_i & r_pending) : '0;
    assign w_acc_any = |w_acc_vec;

    // Priority encoder: scanning downward, so the lowest set index is the
    // last one written and therefore wins.
    always_comb begin
        w_acc_idx = '0;
        for (int n = NUM_CH - 1; n >= 0; n--) begin
            if (w_acc_vec[n]) begin
                w_acc_idx = NUM_CH_LOG2'(n);
            end
        end
    end

    assign w_acc_onehot  = NUM_CH'(w_acc_any) << w_acc_idx;
    assign w_pending_nxt = r_pending & ~w_acc_onehot;

    // Next-state and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_hit = 1'b0;
        core_pop_o    = '0;
        frame_valid_o = 1'b0;
        timeout_o     = 1'b0;
        busy_o        = 1'b0;
        overrun_o     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (frame_i) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority: a last ack landing on the final
                // timeout cycle still yields a complete frame.
                if (w_pending_nxt == '0) begin
                    w_state_nxt = ST_COMMIT;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt   = ST_COMMIT;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are forced low while reset is held, even before the
        // synchronous reset has taken effect on the state register.
        if (!rst) begin
            busy_o    = (r_state != ST_IDLE);
            overrun_o = r_overrun;
            if (r_state == ST_ISSUE) begin
                core_pop_o = r_pending;
            end
            if (r_state == ST_COMMIT) begin
                frame_valid_o = 1'b1;
                timeout_o     = r_timeout;
            end
        end
    end

    assign w_enter_commit = (r_state == ST_WAIT) && (w_state_nxt == ST_COMMIT);
    assign frame_data_o   = r_frame;

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_to_cnt  <= '0;
            r_frame   <= '0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                r_stage[n] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            // Any strobe outside IDLE is a frame we cannot take.
            r_overrun <= frame_i && (r_state != ST_IDLE);
            // Only set on the edge into COMMIT, so it self-clears after one cycle.
            r_timeout <= w_timeout_hit;

            case (r_state)
                ST_IDLE: begin
                    if (frame_i) begin
                        r_pending <= ch_en_i;
                    end
                end
                ST_ISSUE: begin
                    r_pending <= w_pending_nxt;
                    r_to_cnt  <= '0;
                end
                ST_WAIT: begin
                    r_pending <= w_pending_nxt;
                    r_to_cnt  <= r_to_cnt + 1'b1;
                end
                ST_COMMIT: begin
                    // Drop whatever a timed-out frame left outstanding so
                    // stale acks cannot be accepted later.
                    r_pending <= '0;
                end
                default: begin
                    r_pending <= '0;
                end
            endcase

            if (w_acc_any) begin
                r_stage[w_acc_idx] <= core_data_i;
            end

            // The ack accepted in the same cycle as the commit decision is
            // bypassed straight into the frame, since staging only updates
            // at this same edge. Slots with no new data keep their staging
            // value, which equals their last committed value.
            if (w_enter_commit) begin
                for (int n = 0; n < NUM_CH; n++) begin
                    r_frame[24*n +: 24] <= w_acc_onehot[n] ? core_data_i : r_stage[n];
                end
            end
        end
    end

endmodule

// File: doc/resampler_frame_sched.md
RESAMPLER_FRAME_SCHED -- requirements
Module: resampler_frame_sched

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8, meaning the number of resampler channels served.
REQ-002 The block SHALL have parameter NUM_CH_LOG2, default 3, meaning log2(NUM_CH).
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum WAIT cycles per frame.
REQ-004 The block SHALL have parameter TIMEOUT_LOG2, default 10, meaning the width of the timeout counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port frame_i, input, 1 bit: one-cycle output-frame strobe.
REQ-008 The block SHALL have port ch_en_i, input, NUM_CH bits: per-channel enable, sampled on an accepted frame_i.
REQ-009 The block SHALL have port core_pop_o, output, NUM_CH bits: pop request to the resampler core (its pop_i).
REQ-010 The block SHALL have port core_data_i, input, 24 bits: resampler core result (its data_o).
REQ-011 The block SHALL have port core_ack_i, input, NUM_CH bits: resampler core per-channel completion (its ack_o).
REQ-012 The block SHALL have port frame_data_o, output, 24*NUM_CH bits: committed frame; channel n occupies bits [24n+23:24n].
REQ-013 The block SHALL have port frame_valid_o, output, 1 bit: one-cycle pulse when frame_data_o updates.
REQ-014 The block SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The block SHALL have port overrun_o, output, 1 bit: one-cycle pulse when frame_i is dropped.
REQ-016 The block SHALL have port timeout_o, output, 1 bit: one-cycle pulse when a frame commits incomplete.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and COMMIT, each of which other than WAIT lasts exactly 1 cycle.
REQ-018 In IDLE with frame_i=1, the block SHALL latch ch_en_i into a pending mask and go to ISSUE.
REQ-019 In ISSUE, core_pop_o SHALL equal the pending mask for exactly that cycle; at all other times it SHALL be 0.
REQ-020 ISSUE SHALL go to WAIT; the timeout counter SHALL be cleared on entry to WAIT and SHALL increment each WAIT cycle.
REQ-021 In ISSUE and WAIT, a core_ack_i bit n SHALL be accepted only if pending[n]=1: core_data_i is stored to staging slot n and pending[n] is cleared at the next edge.
REQ-022 If more than one pending ack bit is high in the same cycle, the block SHALL accept only the lowest index; the others SHALL remain pending.
REQ-023 Acks for non-pending channels, and all acks received in IDLE or COMMIT, SHALL be ignored.
REQ-024 WAIT SHALL go to COMMIT when the pending mask, after removing this cycle's accepted ack, is zero.
REQ-025 WAIT SHALL go to COMMIT with a timeout when the counter equals TIMEOUT-1 and the pending mask is still nonzero after this cycle's ack.
REQ-026 On the edge entering COMMIT, frame_data_o SHALL load all staging slots and frame_valid_o SHALL be 1 during COMMIT only.
REQ-027 On a timeout, timeout_o SHALL be 1 during COMMIT.
REQ-028 Unserviced and disabled slots SHALL retain their previous frame value.
REQ-029 COMMIT SHALL go to IDLE; frame_i arriving in COMMIT SHALL be dropped.
REQ-030 If frame_i=1 in ISSUE, WAIT or COMMIT, the block SHALL ignore it and pulse overrun_o in the following cycle, leaving the current frame unaffected.
REQ-031 An all-zero ch_en_i SHALL traverse IDLE->ISSUE->WAIT->COMMIT in 4 cycles with no pop, and frame_valid_o SHALL pulse with unchanged data.
REQ-032 Latency SHALL be as follows: frame_i at cycle t gives core_pop_o at t+1; if the last ack arrives at cycle u, frame_valid_o is at u+1.

Reset
REQ-033 When rst=1 at any edge, including mid-frame, the block SHALL enter IDLE and clear the pending mask, the timeout counter, the staging slots and frame_data_o to 0.
REQ-034 While rst=1, core_pop_o, frame_valid_o, overrun_o, timeout_o and busy_o SHALL all be 0.
REQ-035 An ack arriving after reset SHALL be ignored.

Verification
REQ-036 The bench SHALL apply ch_en_i=8'hFF with frame_i, then acks ch0..7 singly on consecutive cycles with data 0x100+n; the required response is a single core_pop_o=8'hFF cycle, frame_valid_o 1 cycle after the ch7 ack, slot n=0x100+n, and timeout_o=0.
REQ-037 The bench SHALL apply ch_en_i=8'h05 and ack ch0 only; the required response is frame_valid_o and timeout_o together TIMEOUT+1 cycles after ISSUE, slot0 updated, and slot2 holding its previous value.
REQ-038 The bench SHALL apply core_ack_i=8'h0A in one cycle with both channels pending; the required response is ch1 captured, ch3 still pending, and a later ch3 ack completing the frame.
REQ-039 The bench SHALL apply frame_i during WAIT; the required response is overrun_o pulsed once and the in-flight frame committing normally.
REQ-040 The bench SHALL apply rst in WAIT after 3 acks; the required response is busy_o=0 next cycle, frame_data_o all zero, and a later ack causing no state change.
REQ-041 The bench SHALL apply ch_en_i=0 with frame_i; the required response is no pop, frame_valid_o at t+3, and data unchanged.
